// File: rtl/esm_pkg.sv
// Shared definitions for the ESM dispatch path: RV32 opcodes, bundle widths
// and the RegWrite/ALUSrc decode used when an instruction enters the tracker.
package esm_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 7;
    localparam int RD_W    = 5;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic reg_write;
        logic alu_src;
    } dec_flags_t;

    // ALUSrc follows IRT semantics: 1 means rs2 is read as a register operand.
    function automatic dec_flags_t decode_flags(input logic [OPC_W-1:0] opcode,
                                                input logic [RD_W-1:0]  rd);
        dec_flags_t f;
        f.reg_write = 1'b0;
        f.alu_src   = 1'b0;
        case (opcode)
            OPC_OP: begin
                f.reg_write = 1'b1;
                f.alu_src   = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                f.reg_write = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                f.alu_src = 1'b1;
            end
            default: begin
                f.reg_write = 1'b0;
                f.alu_src   = 1'b0;
            end
        endcase
        if (rd == 5'd0) begin
            f.reg_write = 1'b0;
        end else begin
            f.reg_write = f.reg_write;
        end
        return f;
    endfunction

endpackage

// File: rtl/esm_prio_enc.sv
// Lowest-index-first priority encoder over a request vector (the free slots).
module esm_prio_enc #(
    parameter int BS = 16
) (
    input  logic [BS-1:0]         req,
    output logic [$clog2(BS)-1:0] idx,
    output logic                  any_free
);

    localparam int IW = $clog2(BS);

    logic found_s;

    // Scan upward so the first set bit wins.
    always_comb begin
        idx     = {IW{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < BS; i++) begin
            if (req[i] && !found_s) begin
                idx     = IW'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_free = |req;
    end

endmodule

// File: rtl/esm_dispatch_alloc.sv
// Dispatch allocator: grabs the lowest free instruction-buffer slot on accept and
// presents a registered (instr, slot, RegWrite, ALUSrc) bundle one cycle later.
module esm_dispatch_alloc
    import esm_pkg::*;
#(
    parameter int Instruction_word_size = INSTR_W,
    parameter int bs                    = 16,
    parameter int regnum                = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [Instruction_word_size-1:0] in_instr,
    input  logic                             free_valid,
    input  logic [$clog2(bs)-1:0]            free_index,
    output logic                             out_valid,
    output logic [Instruction_word_size-1:0] out_instr,
    output logic [$clog2(bs)-1:0]            out_index,
    output logic                             out_RegWrite,
    output logic                             out_ALUSrc,
    output logic [$clog2(bs):0]              occupancy,
    output logic                             free_err
);

    localparam int IW = $clog2(bs);
    localparam int OW = IW + 1;

    // regnum only sizes downstream tables; kept here so both blocks share one value.
    if (regnum < 1 || bs < 2) begin : g_bad_params
    end

    logic [bs-1:0] busy_r;
    logic [bs-1:0] busy_nxt_s;
    logic [bs-1:0] free_vec_s;
    logic [bs-1:0] set_mask_s;
    logic [bs-1:0] clr_mask_s;
    logic [IW-1:0] alloc_idx_s;
    logic          any_free_s;
    logic          accept_s;
    logic          valid_free_s;
    logic [OW-1:0] occ_nxt_s;
    dec_flags_t    dec_s;

    assign free_vec_s = ~busy_r;

    esm_prio_enc #(.BS(bs)) u_prio (
        .req      (free_vec_s),
        .idx      (alloc_idx_s),
        .any_free (any_free_s)
    );

    // in_ready depends on the registered bitmap alone, so a same-cycle free
    // cannot create a combinational path to upstream.
    assign in_ready = any_free_s;

    // Accept and free touch disjoint slots (clear vs. set bit), so both masks apply.
    always_comb begin
        accept_s     = in_valid & any_free_s;
        valid_free_s = free_valid & busy_r[free_index];
        set_mask_s   = accept_s     ? ({{(bs-1){1'b0}}, 1'b1} << alloc_idx_s) : {bs{1'b0}};
        clr_mask_s   = valid_free_s ? ({{(bs-1){1'b0}}, 1'b1} << free_index)  : {bs{1'b0}};
        busy_nxt_s   = (busy_r | set_mask_s) & ~clr_mask_s;
        occ_nxt_s    = occupancy + OW'(accept_s) - OW'(valid_free_s);
        dec_s        = decode_flags(in_instr[6:0], in_instr[11:7]);
    end

    // Bitmap, occupancy, sticky error and the dispatch output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r       <= {bs{1'b0}};
            occupancy    <= {OW{1'b0}};
            free_err     <= 1'b0;
            out_valid    <= 1'b0;
            out_instr    <= {Instruction_word_size{1'b0}};
            out_index    <= {IW{1'b0}};
            out_RegWrite <= 1'b0;
            out_ALUSrc   <= 1'b0;
        end else begin
            busy_r    <= busy_nxt_s;
            occupancy <= occ_nxt_s;
            free_err  <= free_err | (free_valid & ~busy_r[free_index]);
            out_valid <= accept_s;
            if (accept_s) begin
                out_instr    <= in_instr;
                out_index    <= alloc_idx_s;
                out_RegWrite <= dec_s.reg_write;
                out_ALUSrc   <= dec_s.alu_src;
            end
        end
    end

endmodule

// File: tb/tb_esm_dispatch_alloc.sv
// Directed self-checking bench for esm_dispatch_alloc (bs=16, 32-bit instructions).
module tb_esm_dispatch_alloc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        free_valid;
    logic [3:0]  free_index;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [3:0]  out_index;
    logic        out_RegWrite;
    logic        out_ALUSrc;
    logic [4:0]  occupancy;
    logic        free_err;

    int total = 0;
    int bad   = 0;

    esm_dispatch_alloc #(.Instruction_word_size(32), .bs(16), .regnum(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .free_valid   (free_valid),
        .free_index   (free_index),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_index    (out_index),
        .out_RegWrite (out_RegWrite),
        .out_ALUSrc   (out_ALUSrc),
        .occupancy    (occupancy),
        .free_err     (free_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; in_instr = 32'h0; free_valid = 1'b0; free_index = 4'd0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (occupancy !== 5'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (free_err !== 1'b0) begin bad++; $display("FAIL reset_free_err got=%b exp=0", free_err); end
        total++; if (out_instr !== 32'h0 || out_index !== 4'd0 || out_RegWrite !== 1'b0 || out_ALUSrc !== 1'b0) begin
            bad++; $display("FAIL reset_bundle got=%h/%0d/%b/%b exp=0/0/0/0", out_instr, out_index, out_RegWrite, out_ALUSrc);
        end
        rst = 1'b1;
    endtask

    task automatic test_first_accept;
        in_valid = 1'b1; in_instr = 32'h00208033;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_index !== 4'd0 || out_instr !== 32'h00208033) begin
            bad++; $display("FAIL first_accept got=%b/%0d/%h exp=1/0/00208033", out_valid, out_index, out_instr);
        end
        total++; if (out_RegWrite !== 1'b0 || out_ALUSrc !== 1'b1) begin
            bad++; $display("FAIL first_flags got=%b%b exp=01", out_RegWrite, out_ALUSrc);
        end
        total++; if (occupancy !== 5'd1) begin bad++; $display("FAIL first_occ got=%0d exp=1", occupancy); end
        tick();
        total++; if (out_valid !== 1'b0 || out_index !== 4'd0 || out_instr !== 32'h00208033) begin
            bad++; $display("FAIL first_hold got=%b/%0d/%h exp=0/0/00208033", out_valid, out_index, out_instr);
        end
        free_valid = 1'b1; free_index = 4'd0;
        tick();
        free_valid = 1'b0;
        total++; if (occupancy !== 5'd0 || free_err !== 1'b0) begin
            bad++; $display("FAIL first_free got=%0d/%b exp=0/0", occupancy, free_err);
        end
    endtask

    task automatic test_back_to_back;
        in_valid = 1'b1; in_instr = 32'h00A00093;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++; if (out_valid !== 1'b1 || out_index !== 4'(i) || out_RegWrite !== 1'b1 || out_ALUSrc !== 1'b0) begin
                bad++; $display("FAIL b2b_%0d got=%b/%0d/%b%b exp=1/%0d/10", i, out_valid, out_index, out_RegWrite, out_ALUSrc, i);
            end
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b exp=0", in_ready); end
        total++; if (occupancy !== 5'd16) begin bad++; $display("FAIL b2b_occ got=%0d exp=16", occupancy); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || occupancy !== 5'd16) begin
            bad++; $display("FAIL b2b_blocked got=%b/%0d exp=0/16", out_valid, occupancy);
        end
    endtask

    task automatic test_full_free;
        free_valid = 1'b1; free_index = 4'd5;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_free_same_cycle got=%b exp=0", in_ready); end
        tick();
        free_valid = 1'b0;
        total++; if (in_ready !== 1'b1 || occupancy !== 5'd15) begin
            bad++; $display("FAIL full_free_next got=%b/%0d exp=1/15", in_ready, occupancy);
        end
        in_valid = 1'b1; in_instr = 32'h00A00093;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_index !== 4'd5 || occupancy !== 5'd16 || in_ready !== 1'b0) begin
            bad++; $display("FAIL full_realloc got=%b/%0d/%0d/%b exp=1/5/16/0", out_valid, out_index, occupancy, in_ready);
        end
    endtask

    task automatic test_same_cycle;
        pulse_reset();
        in_valid = 1'b1; in_instr = 32'h00A00093;
        repeat (3) tick();
        free_valid = 1'b1; free_index = 4'd0;
        tick();
        free_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_index !== 4'd3 || occupancy !== 5'd3) begin
            bad++; $display("FAIL same_cycle got=%b/%0d/%0d exp=1/3/3", out_valid, out_index, occupancy);
        end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_index !== 4'd0 || occupancy !== 5'd4) begin
            bad++; $display("FAIL same_cycle_reuse got=%b/%0d/%0d exp=1/0/4", out_valid, out_index, occupancy);
        end
    endtask

    task automatic test_free_err;
        free_valid = 1'b1; free_index = 4'd9;
        tick();
        free_valid = 1'b0;
        total++; if (free_err !== 1'b1 || occupancy !== 5'd4) begin
            bad++; $display("FAIL free_err_set got=%b/%0d exp=1/4", free_err, occupancy);
        end
        free_valid = 1'b1; free_index = 4'd1;
        tick();
        free_valid = 1'b0;
        tick();
        total++; if (free_err !== 1'b1 || occupancy !== 5'd3) begin
            bad++; $display("FAIL free_err_sticky got=%b/%0d exp=1/3", free_err, occupancy);
        end
    endtask

    task automatic test_decode;
        logic [31:0] vec [10];
        logic [1:0]  flg [10];
        logic [3:0]  slot [10];
        vec = '{32'h0002A283, 32'h0062A023, 32'h00208463, 32'h123451B7, 32'h00000517,
                32'h008000EF, 32'h000080E7, 32'h00000FFF, 32'h00000013, 32'h003100B3};
        flg = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b11};
        slot = '{4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_instr = vec[i];
            tick();
            total++; if (out_valid !== 1'b1 || out_instr !== vec[i] || out_index !== slot[i] ||
                         {out_RegWrite, out_ALUSrc} !== flg[i]) begin
                bad++; $display("FAIL decode_%0d got=%b/%h/%0d/%b%b exp=1/%h/%0d/%b",
                                i, out_valid, out_instr, out_index, out_RegWrite, out_ALUSrc, vec[i], slot[i], flg[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        total++; if (occupancy !== 5'd13) begin bad++; $display("FAIL decode_occ got=%0d exp=13", occupancy); end
    endtask

    task automatic test_reset_mid;
        pulse_reset();
        total++; if (free_err !== 1'b0) begin bad++; $display("FAIL reset_clears_err got=%b exp=0", free_err); end
        in_valid = 1'b1; in_instr = 32'h00A00093;
        repeat (7) tick();
        total++; if (occupancy !== 5'd7 || out_index !== 4'd6) begin
            bad++; $display("FAIL mid_burst got=%0d/%0d exp=7/6", occupancy, out_index);
        end
        #2 rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || occupancy !== 5'd0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_reset_async got=%b/%0d/%b exp=0/0/1", out_valid, occupancy, in_ready);
        end
        tick();
        rst = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_index !== 4'd0 || occupancy !== 5'd1) begin
            bad++; $display("FAIL after_reset_alloc got=%b/%0d/%0d exp=1/0/1", out_valid, out_index, occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_back_to_back();
        test_full_free();
        test_same_cycle();
        test_free_err();
        test_decode();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
